// File: rtl/gnn_save_stream_reader.sv
// rtl/gnn_save_stream_reader.sv - strided, credit-based buffer-bank reader feeding an AXI-Stream-style save path
module gnn_save_stream_reader #(
   parameter int NUM_BUFS       = 4,
   parameter int DATA_WIDTH     = 512,
   parameter int BUF_ADDR_WIDTH = 11,
   parameter int LEN_WIDTH      = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter int RD_LATENCY     = 2
) (
   input  logic                               aclk,
   input  logic                               areset,
   input  logic                               start,
   input  logic [NUM_BUFS-1:0]                cfg_sel,
   input  logic [BUF_ADDR_WIDTH-1:0]          cfg_base_addr,
   input  logic [LEN_WIDTH-1:0]               cfg_len,
   input  logic [BUF_ADDR_WIDTH-1:0]          cfg_stride,
   output logic                               busy,
   output logic                               done,
   output logic                               err_sel,
   output logic [NUM_BUFS-1:0]                buf_avalid,
   output logic [NUM_BUFS*BUF_ADDR_WIDTH-1:0] buf_addr,
   input  logic [NUM_BUFS-1:0]                buf_valid,
   input  logic [NUM_BUFS*DATA_WIDTH-1:0]     buf_data,
   output logic                               m_tvalid,
   input  logic                               m_tready,
   output logic [DATA_WIDTH-1:0]              m_tdata,
   output logic                               m_tlast
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   // The FIFO must be able to absorb every read already in the bank pipeline.
   if (FIFO_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
      $error("FIFO_DEPTH too small for RD_LATENCY");
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                    state, state_nxt;
   logic [NUM_BUFS-1:0]       sel_q;
   logic [LEN_WIDTH-1:0]      len_q;
   logic [BUF_ADDR_WIDTH-1:0] stride_q;
   logic [BUF_ADDR_WIDTH-1:0] addr_acc;
   logic [LEN_WIDTH-1:0]      issued;
   logic [LEN_WIDTH-1:0]      accepted;
   logic [CNT_W-1:0]          outstanding;
   logic                      err_sel_q;

   logic [DATA_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [CNT_W-1:0]          fifo_count;

   logic                      sel_onehot, start_ok, active, credit_ok;
   logic                      issue, rd_valid, beat, at_last, last_beat;
   logic [DATA_WIDTH-1:0]     rd_data;

   assign sel_onehot = (cfg_sel != '0) && ((cfg_sel & (cfg_sel - NUM_BUFS'(1))) == '0);
   assign start_ok   = (state == S_IDLE) && start && sel_onehot;
   assign active     = (state == S_RUN) || (state == S_DRAIN);
   assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C;
   assign issue      = (state == S_RUN) && (issued < len_q) && credit_ok;
   assign rd_valid   = active && ((buf_valid & sel_q) != '0);
   assign beat       = m_tvalid && m_tready;
   assign at_last    = accepted == (len_q - LEN_WIDTH'(1));
   assign last_beat  = beat && at_last;

   assign busy     = active;
   assign done     = (state == S_DONE);
   assign err_sel  = err_sel_q;
   assign m_tvalid = (fifo_count != '0);
   assign m_tdata  = m_tvalid ? fifo_mem[rd_ptr] : '0;
   assign m_tlast  = m_tvalid && at_last;

   // Drive the read request and address only on the selected bank, only while issuing.
   always_comb begin
      buf_avalid = '0;
      buf_addr   = '0;
      for (int k = 0; k < NUM_BUFS; k++) begin
         if (issue && sel_q[k]) begin
            buf_avalid[k] = 1'b1;
            buf_addr[k*BUF_ADDR_WIDTH +: BUF_ADDR_WIDTH] = addr_acc;
         end
      end
   end

   // Select the returning data lane of the latched bank.
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NUM_BUFS; k++) begin
         if (sel_q[k]) begin
            rd_data = rd_data | buf_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state logic: finish issuing, then wait until the final beat leaves.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               state_nxt = (cfg_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (issued == len_q) begin
               state_nxt = last_beat ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (last_beat) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register, command latch, address walk and transfer counters.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state       <= S_IDLE;
         sel_q       <= '0;
         len_q       <= '0;
         stride_q    <= '0;
         addr_acc    <= '0;
         issued      <= '0;
         accepted    <= '0;
         outstanding <= '0;
         err_sel_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         err_sel_q <= (state == S_IDLE) && start && !sel_onehot;
         if (start_ok) begin
            sel_q    <= cfg_sel;
            len_q    <= cfg_len;
            stride_q <= cfg_stride;
            addr_acc <= cfg_base_addr;
            issued   <= '0;
            accepted <= '0;
         end else begin
            if (issue) begin
               issued   <= issued + LEN_WIDTH'(1);
               addr_acc <= addr_acc + stride_q;
            end
            if (beat) begin
               accepted <= accepted + LEN_WIDTH'(1);
            end
         end
         case ({issue, rd_valid})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // FIFO pointers and occupancy; the credit rule guarantees a write always has room.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (rd_valid) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (beat) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({rd_valid, beat})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // FIFO storage; contents need no reset because m_tdata is masked while empty.
   always_ff @(posedge aclk) begin
      if (rd_valid) begin
         fifo_mem[wr_ptr] <= rd_data;
      end
   end

endmodule

// File: tb/tb_gnn_save_stream_reader.sv
// tb/tb_gnn_save_stream_reader.sv - scoreboard bench for gnn_save_stream_reader
module tb_gnn_save_stream_reader;

   localparam int NB = 4;
   localparam int DW = 512;
   localparam int AW = 11;
   localparam int LW = 16;

   typedef struct {
      logic [DW-1:0] d;
      logic          last;
   } beat_t;

   logic              aclk = 1'b0;
   logic              areset = 1'b1;
   logic              start = 1'b0;
   logic [NB-1:0]     cfg_sel = '0;
   logic [AW-1:0]     cfg_base_addr = '0;
   logic [LW-1:0]     cfg_len = '0;
   logic [AW-1:0]     cfg_stride = '0;
   logic              busy, done, err_sel;
   logic [NB-1:0]     buf_avalid;
   logic [NB*AW-1:0]  buf_addr;
   logic [NB-1:0]     buf_valid;
   logic [NB*DW-1:0]  buf_data;
   logic              m_tvalid;
   logic              m_tready = 1'b1;
   logic [DW-1:0]     m_tdata;
   logic              m_tlast;

   gnn_save_stream_reader dut (
      .aclk(aclk), .areset(areset), .start(start), .cfg_sel(cfg_sel),
      .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len), .cfg_stride(cfg_stride),
      .busy(busy), .done(done), .err_sel(err_sel),
      .buf_avalid(buf_avalid), .buf_addr(buf_addr), .buf_valid(buf_valid), .buf_data(buf_data),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int av_cnt = 0, beat_cnt = 0, done_cnt = 0, err_cnt = 0, tlast_cnt = 0;
   int max_inflight = 0;
   int first_av = -1, first_beat = -1, done_cyc = -1;
   bit rand_rdy = 0;
   beat_t exp_beats[$];
   int    exp_addr[$];

   function automatic logic [DW-1:0] mk(input int b, input int a);
      logic [31:0] w;
      w = {8'hA5, 8'(b), 5'd0, 11'(a)};
      return {16{w}};
   endfunction

   // Bank model: fixed two-cycle read latency, data derived from bank and address.
   logic [NB-1:0] pv0 = '0, pv1 = '0;
   logic [AW-1:0] pa0 [NB];
   logic [AW-1:0] pa1 [NB];
   always @(posedge aclk) begin
      pv0 <= buf_avalid;
      pv1 <= pv0;
      for (int k = 0; k < NB; k++) begin
         pa0[k] <= buf_addr[k*AW +: AW];
         pa1[k] <= pa0[k];
      end
   end
   always_comb begin
      buf_valid = pv1;
      buf_data  = '0;
      for (int k = 0; k < NB; k++) buf_data[k*DW +: DW] = mk(k, int'(pa1[k]));
   end

   always @(posedge aclk) cyc <= cyc + 1;

   // Monitor: checks reads and beats against the scoreboard queues.
   always @(negedge aclk) begin
      if (!areset) begin
         for (int k = 0; k < NB; k++) begin
            if (buf_avalid[k]) begin
               int e;
               av_cnt++;
               if (first_av < 0) first_av = cyc;
               checks++;
               if (exp_addr.size() == 0) begin
                  errors++;
                  $display("FAIL rd_addr unexpected read bank %0d addr %0d", k, buf_addr[k*AW +: AW]);
               end else begin
                  e = exp_addr.pop_front();
                  if (e != k*65536 + int'(buf_addr[k*AW +: AW])) begin
                     errors++;
                     $display("FAIL rd_addr got bank %0d addr %0d expected bank %0d addr %0d",
                              k, buf_addr[k*AW +: AW], e / 65536, e % 65536);
                  end
               end
            end
         end
         if (m_tvalid && m_tready) begin
            beat_t b;
            beat_cnt++;
            if (m_tlast) tlast_cnt++;
            if (first_beat < 0) first_beat = cyc;
            checks++;
            if (exp_beats.size() == 0) begin
               errors++;
               $display("FAIL beat unexpected data %h", m_tdata[63:0]);
            end else begin
               b = exp_beats.pop_front();
               if (m_tdata !== b.d || m_tlast !== b.last) begin
                  errors++;
                  $display("FAIL beat got data %h last %b expected data %h last %b",
                           m_tdata[63:0], m_tlast, b.d[63:0], b.last);
               end
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (err_sel) err_cnt++;
         if (av_cnt - beat_cnt > max_inflight) max_inflight = av_cnt - beat_cnt;
      end
   end

   // Random back-pressure driver.
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmd(input logic [3:0] sel, input int base, input int len, input int stride,
                      input bit push, output int c0);
      int b;
      @(posedge aclk);
      #1;
      cfg_sel = sel; cfg_base_addr = AW'(base); cfg_len = LW'(len); cfg_stride = AW'(stride);
      start = 1'b1;
      c0 = cyc;
      if (push) begin
         b = (sel == 4'b0001) ? 0 : (sel == 4'b0010) ? 1 : (sel == 4'b0100) ? 2 : 3;
         for (int i = 0; i < len; i++) begin
            beat_t e;
            int a;
            a = (base + i * stride) % 2048;
            e.d = mk(b, a);
            e.last = (i == len - 1);
            exp_beats.push_back(e);
            exp_addr.push_back(b * 65536 + a);
         end
      end
      @(posedge aclk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_until_done(input string name, input int budget);
      int d0, n;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(posedge aclk);
         n++;
      end
      #1;
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL %s timeout waiting for done", name);
      end
      chk({name, "_beats_left"}, 64'(exp_beats.size()), 0);
      chk({name, "_reads_left"}, 64'(exp_addr.size()), 0);
   endtask

   initial begin
      int c0, a0, b0, d0, e0, t0;

      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, a0, b0, d0, e0, t0;

      repeat (3) @(posedge aclk);
      #1;
      chk("rst_busy", 64'(busy), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_err_sel", 64'(err_sel), 0);
      chk("rst_tvalid", 64'(m_tvalid), 0);
      chk("rst_tlast", 64'(m_tlast), 0);
      chk("rst_avalid", 64'(buf_avalid), 0);
      chk("rst_addr", 64'(buf_addr), 0);
      chk("rst_tdata", 64'(|m_tdata), 0);
      areset = 1'b0;

      // Basic run with latency checks.
      first_av = -1; first_beat = -1;
      cmd(4'b0001, 10, 4, 1, 1, c0);
      chk("t1_busy", 64'(busy), 1);
      run_until_done("t1", 50);
      chk("t1_first_av", 64'(first_av), 64'(c0 + 1));
      chk("t1_first_beat", 64'(first_beat), 64'(c0 + 4));
      chk("t1_done_cyc", 64'(done_cyc), 64'(c0 + 8));
      chk("t1_busy_after", 64'(busy), 0);

      // Back-pressure with address wrap; credit fills exactly to FIFO depth.
      m_tready = 1'b0;
      a0 = av_cnt; b0 = beat_cnt;
      cmd(4'b0100, 2040, 16, 3, 1, c0);
      repeat (20) @(posedge aclk);
      #1;
      chk("t2_inflight", 64'((av_cnt - a0) - (beat_cnt - b0)), 8);
      chk("t2_no_beats", 64'(beat_cnt - b0), 0);
      chk("t2_tvalid_held", 64'(m_tvalid), 1);
      m_tready = 1'b1;
      run_until_done("t2", 200);

      // Random back-pressure, long transfer.
      d0 = done_cnt; t0 = tlast_cnt;
      rand_rdy = 1;
      cmd(4'b1000, 100, 100, 5, 1, c0);
      run_until_done("t3", 2000);
      rand_rdy = 0;
      m_tready = 1'b1;
      repeat (5) @(posedge aclk);
      #1;
      chk("t3_done_once", 64'(done_cnt - d0), 1);
      chk("t3_tlast_once", 64'(tlast_cnt - t0), 1);
      chk("t3_max_inflight_le8", 64'(max_inflight <= 8), 1);

      // Bad selects and zero length.
      e0 = err_cnt; a0 = av_cnt;
      cmd(4'b0110, 0, 4, 1, 0, c0);
      chk("t4a_busy", 64'(busy), 0);
      cmd(4'b0000, 0, 4, 1, 0, c0);
      chk("t4b_busy", 64'(busy), 0);
      repeat (4) @(posedge aclk);
      #1;
      chk("t4_err_pulses", 64'(err_cnt - e0), 2);
      chk("t4_no_reads", 64'(av_cnt - a0), 0);
      d0 = done_cnt; b0 = beat_cnt;
      cmd(4'b0001, 0, 0, 1, 0, c0);
      repeat (4) @(posedge aclk);
      #1;
      chk("t4_len0_done", 64'(done_cnt - d0), 1);
      chk("t4_len0_beats", 64'(beat_cnt - b0), 0);
      chk("t4_len0_reads", 64'(av_cnt - a0), 0);

      // Start while busy is ignored.
      d0 = done_cnt;
      cmd(4'b0001, 0, 10, 2, 1, c0);
      repeat (2) @(posedge aclk);
      cmd(4'b0010, 500, 3, 1, 0, c0);
      run_until_done("t5", 100);
      a0 = av_cnt;
      repeat (10) @(posedge aclk);
      #1;
      chk("t5_done_once", 64'(done_cnt - d0), 1);
      chk("t5_no_extra_reads", 64'(av_cnt - a0), 0);

      // Reset mid-run with three words buffered, then a clean command.
      m_tready = 1'b0;
      cmd(4'b0010, 7, 10, 1, 1, c0);
      repeat (5) @(posedge aclk);
      #1;
      chk("t6_pre_tvalid", 64'(m_tvalid), 1);
      areset = 1'b1;
      #1;
      chk("t6_rst_tvalid", 64'(m_tvalid), 0);
      chk("t6_rst_busy", 64'(busy), 0);
      exp_beats.delete();
      exp_addr.delete();
      @(posedge aclk);
      #1;
      areset = 1'b0;
      m_tready = 1'b1;
      repeat (4) @(posedge aclk);
      #1;
      chk("t6_post_tvalid", 64'(m_tvalid), 0);
      chk("t6_post_busy", 64'(busy), 0);
      cmd(4'b0001, 20, 5, 2, 1, c0);
      run_until_done("t6", 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
